// File: rtl/tc_pkg.sv
// Shared encodings for the bit-serial two's-complement sequencer:
// operation codes, FSM states and the negate-decision helper.
package tc_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_NEG  = 2'b01,
        OP_ABS  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Reserved op behaves as pass; abs negates only negative operands.
    function automatic logic neg_needed(input op_e op, input logic msb);
        case (op)
            OP_NEG:  return 1'b1;
            OP_ABS:  return msb;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tc_serial_bit.sv
// One bit-slice of the copy-until-first-one rule: bits up to and including
// the first 1 pass through, every later bit is inverted when negating.
module tc_serial_bit (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic do_neg,
    input  logic b_in,
    output logic r_out
);

    logic r_seen_one;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_seen_one <= 1'b0;
        end else if (en) begin
            r_seen_one <= r_seen_one | b_in;
        end
    end

    assign r_out = b_in ^ (do_neg & r_seen_one);

endmodule

// File: rtl/serial_twos_complement_ctrl.sv
// Bit-serial pass/negate/abs sequencer: accepts an operand on a valid/ready
// handshake, processes it LSB-first one bit per clock, then offers the result.
module serial_twos_complement_ctrl
    import tc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           r_state;
    state_e           w_state_next;
    op_e              r_op;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_shift_en;
    logic             w_last;
    logic             w_do_neg;
    logic             w_bit;
    logic [WIDTH-1:0] w_res_next;

    assign w_last     = (r_cnt == CNT_LAST);
    assign w_do_neg   = neg_needed(r_op, r_operand[WIDTH-1]);
    assign w_res_next = {w_bit, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy       = 1'b1;
                w_shift_en = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= OP_PASS;
            r_operand  <= '0;
            r_sh       <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_op      <= op_e'(in_op);
            r_operand <= in_data;
            r_sh      <= in_data;
            r_res     <= '0;
            r_cnt     <= '0;
        end else if (w_shift_en) begin
            r_sh  <= r_sh >> 1;
            r_res <= w_res_next;
            r_cnt <= r_cnt + CNT_ONE;
            // The most-negative value maps onto itself; flag it instead of widening.
            if (w_last) begin
                r_out_data <= w_res_next;
                r_out_ovf  <= w_do_neg && (r_operand == MOST_NEG);
            end
        end
    end

    tc_serial_bit u_bit (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_accept),
        .en     (w_shift_en),
        .do_neg (w_do_neg),
        .b_in   (r_sh[0]),
        .r_out  (w_bit)
    );

    assign out_data = r_out_data;
    assign out_ovf  = r_out_ovf;

endmodule

// File: tb/tb_serial_twos_complement_ctrl.sv
// Scoreboard bench for serial_twos_complement_ctrl: directed cases, a DONE
// stall, a mid-SHIFT reset and randomized traffic against an arithmetic model.
module tb_serial_twos_complement_ctrl;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             ovf;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       in_op = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             busy;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   force_rdy = 1'b1;
    bit   force_val = 1'b1;
    bit   prev_valid = 1'b0;

    serial_twos_complement_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        out_ready = force_rdy ? force_val : ($urandom_range(0, 2) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain two's-complement arithmetic modulo 2**WIDTH.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [1:0] op, input int acc);
        exp_t e;
        logic neg;
        neg    = (op == 2'b01) || (op == 2'b10 && $signed(d) < 0);
        e.data = neg ? WIDTH'(0 - int'(d)) : d;
        e.ovf  = neg && (int'($signed(d)) == -(2 ** (WIDTH - 1)));
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: latency on each rising out_valid, data/ovf on each hand-off.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h with empty scoreboard", out_data);
                end else begin
                    check("latency", cyc, sb[0].acc + WIDTH);
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_ovf", out_ovf, mon_e.ovf);
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] op);
        bit rdy = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        for (int n = 0; n < 100 && !rdy; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready for operand %0h", d);
        end else begin
            sb.push_back(model(d, op, cyc));
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(posedge clk);
            #3;
        end
        check("drain", sb.size(), 0);
    endtask

    logic [WIDTH-1:0] d_tab [8] = '{4'h7, 4'h0, 4'h1, 4'h8, 4'h8, 4'hC, 4'h3, 4'h6};
    logic [1:0]       o_tab [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            send(d_tab[i], o_tab[i]);
            wait_drain();
        end

        // Stall in DONE with in_valid pulsed throughout SHIFT and DONE.
        force_val = 1'b0;
        send(4'hB, 2'b10);
        in_valid = 1'b1;
        in_data  = 4'h5;
        in_op    = 2'b01;
        @(negedge clk);
        check("in_ready_shift", in_ready, 0);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, (sb.size() != 0) ? 32'(sb[0].data) : 32'hdead);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        force_val = 1'b1;
        @(posedge clk);
        #3;
        check("release_valid", out_valid, 1);
        @(posedge clk);
        #1;
        check("release_in_ready", in_ready, 1);
        check("release_busy", busy, 0);
        check("release_out_valid", out_valid, 0);
        check("stall_sb_empty", sb.size(), 0);

        // Reset mid-SHIFT at counter=2; the partial result must never appear.
        send(4'h9, 2'b01);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (sb.size() != 0) sb.delete(sb.size() - 1);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_ovf", out_ovf, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_data", out_data, 0);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_quiet", out_valid, 0);
        send(4'h9, 2'b01);
        wait_drain();

        force_rdy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            send(WIDTH'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        force_rdy = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
